// File: rtl/tt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tt_ctrl_pkg
// Shared definitions for the controller design-select path: the select/enable
// FSM state encoding, the default select-address width and the layout of the
// select/enable fields on the vertical spine (shared with the branch muxes).
// -----------------------------------------------------------------------------
package tt_ctrl_pkg;

  // Design-select FSM states
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ON     = 2'd2
  } ctrl_state_e;

  // Spine field layout: enable bit at the bottom, select address above it
  localparam int SPINE_SEL_W   = 10;
  localparam int SPINE_ENA_OFS = 0;
  localparam int SPINE_SEL_OFS = 1;
  localparam int SPINE_CTRL_W  = SPINE_SEL_OFS + SPINE_SEL_W;

  // Default design-select address width matches the spine select field
  localparam int DEF_SEL_W = SPINE_SEL_W;

  // Next address for an increment, wrapping to zero past the highest legal one
  function automatic int unsigned next_sel(input int unsigned cur,
                                           input int unsigned max_sel);
    if (cur >= max_sel) begin
      return 32'd0;
    end else begin
      return cur + 32'd1;
    end
  endfunction

endpackage

// File: rtl/tt_sync_edge.sv
// -----------------------------------------------------------------------------
// tt_sync_edge
// Multi-flop synchroniser for one asynchronous pad with a rising-edge strobe.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : raw asynchronous pad input
//   level      : synchronised level (valid SYNC_STAGES edges after sampling)
//   rise       : one-cycle strobe when the synchronised level goes 0 -> 1
// Every flop, including the edge history, resets to RST_VAL so a pad that is
// already at RST_VAL when reset releases never produces a spurious edge.
// -----------------------------------------------------------------------------
module tt_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;

  // Synchroniser shift chain (new sample enters at bit 0) plus level history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{RST_VAL}};
      hist_r <= RST_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/tt_ctrl_sel.sv
// -----------------------------------------------------------------------------
// tt_ctrl_sel
// Design-select front end for the controller. Synchronises the three control
// pads, keeps the selected-design address and sequences the user-module enable
// through a settle window so the enable is never high with a stale address.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   ctrl_sel_rst_n : raw pad, low clears the address
//   ctrl_sel_inc   : raw pad, each rising edge increments the address
//   ctrl_ena       : raw pad, high requests the selected design enabled
//   sel            : current design-select address (spine select field)
//   um_ena         : enable to the selected user module (spine enable bit)
//   busy           : high while the enable is settling
//   sel_chg        : one-cycle pulse on the cycle sel changes
// All outputs are flops; there is no combinational path from pads to outputs.
// -----------------------------------------------------------------------------
module tt_ctrl_sel
  import tt_ctrl_pkg::*;
#(
  parameter int SEL_W       = DEF_SEL_W,
  parameter int MAX_SEL     = 1023,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_sel_rst_n,
  input  logic             ctrl_sel_inc,
  input  logic             ctrl_ena,
  output logic [SEL_W-1:0] sel,
  output logic             um_ena,
  output logic             busy,
  output logic             sel_chg
);

  localparam int             CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  // Synchronised pad levels and strobes
  logic sel_rst_s;
  logic inc_lvl_unused_s;
  logic inc_edge_s;
  logic ena_s;
  logic sel_rst_rise_unused_s;
  logic ena_rise_unused_s;

  // Address update and FSM state
  logic [SEL_W-1:0] sel_nxt_s;
  logic             chg_s;
  logic             ena_ok_s;
  logic [SEL_W-1:0] sel_r;
  logic             sel_chg_r;
  ctrl_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             um_ena_r;
  logic             busy_r;

  // Image of the spine control fields as the controller packs them
  logic [SPINE_CTRL_W-1:0] spine_img_unused_s;

  // Address clear pad: reset low keeps the address cleared until the pad reads high
  tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sel_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ctrl_sel_rst_n),
    .level (sel_rst_s),
    .rise  (sel_rst_rise_unused_s)
  );

  // Increment pad: reset high so a pad held high through reset is not an edge
  tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ctrl_sel_inc),
    .level (inc_lvl_unused_s),
    .rise  (inc_edge_s)
  );

  // Enable request pad
  tt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ena (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ctrl_ena),
    .level (ena_s),
    .rise  (ena_rise_unused_s)
  );

  assign ena_ok_s = ena_s & sel_rst_s;

  // Next address and change event; clear has priority over increment
  always_comb begin
    sel_nxt_s = sel_r;
    chg_s     = 1'b0;
    if (!sel_rst_s) begin
      sel_nxt_s = {SEL_W{1'b0}};
      chg_s     = (sel_r != {SEL_W{1'b0}});
    end else if (inc_edge_s) begin
      sel_nxt_s = SEL_W'(next_sel(32'(sel_r), 32'(MAX_SEL)));
      chg_s     = 1'b1;
    end else begin
      sel_nxt_s = sel_r;
      chg_s     = 1'b0;
    end
  end

  // Address register and its change pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r     <= {SEL_W{1'b0}};
      sel_chg_r <= 1'b0;
    end else begin
      sel_r     <= sel_nxt_s;
      sel_chg_r <= chg_s;
    end
  end

  // Enable sequencer; um_ena/busy are decoded from the state being entered,
  // so um_ena drops on the same edge a new address lands on sel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_OFF;
      cnt_r    <= {CNT_W{1'b0}};
      um_ena_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_OFF: begin
          if (ena_ok_s) begin
            state_r  <= ST_SETTLE;
            cnt_r    <= CNT_LOAD;
            busy_r   <= 1'b1;
            um_ena_r <= 1'b0;
          end else begin
            state_r  <= ST_OFF;
            busy_r   <= 1'b0;
            um_ena_r <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!ena_ok_s) begin
            state_r  <= ST_OFF;
            busy_r   <= 1'b0;
            um_ena_r <= 1'b0;
          end else if (chg_s) begin
            state_r  <= ST_SETTLE;
            cnt_r    <= CNT_LOAD;
            busy_r   <= 1'b1;
            um_ena_r <= 1'b0;
          end else if (cnt_r == {CNT_W{1'b0}}) begin
            state_r  <= ST_ON;
            busy_r   <= 1'b0;
            um_ena_r <= 1'b1;
          end else begin
            state_r  <= ST_SETTLE;
            cnt_r    <= cnt_r - CNT_W'(1);
            busy_r   <= 1'b1;
            um_ena_r <= 1'b0;
          end
        end
        ST_ON: begin
          if (!ena_ok_s) begin
            state_r  <= ST_OFF;
            busy_r   <= 1'b0;
            um_ena_r <= 1'b0;
          end else if (chg_s) begin
            state_r  <= ST_SETTLE;
            cnt_r    <= CNT_LOAD;
            busy_r   <= 1'b1;
            um_ena_r <= 1'b0;
          end else begin
            state_r  <= ST_ON;
            busy_r   <= 1'b0;
            um_ena_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_OFF;
          cnt_r    <= {CNT_W{1'b0}};
          busy_r   <= 1'b0;
          um_ena_r <= 1'b0;
        end
      endcase
    end
  end

  assign spine_img_unused_s[SPINE_ENA_OFS]                = um_ena_r;
  assign spine_img_unused_s[SPINE_SEL_OFS +: SPINE_SEL_W] = SPINE_SEL_W'(sel_r);

  assign sel     = sel_r;
  assign um_ena  = um_ena_r;
  assign busy    = busy_r;
  assign sel_chg = sel_chg_r;

endmodule

// File: doc/tt_ctrl_sel.md
Name: tt_ctrl_sel

Overview:
Clocked design-select front end for the controller.
- Takes the three raw control-pad inputs: select-reset, select-increment and enable.
- Synchronises and edge-detects them, and maintains the selected-design address.
- Sequences the user-module enable with a settle window.
- Its outputs drive the select and enable fields that the controller places on the vertical spine.
- Each branch mux consumes those fields to decode which user module is active.

Parameters:
SEL_W, 10, width of design-select address (matches spine select field)
MAX_SEL, 1023, highest legal address; increment past it wraps to 0
SYNC_STAGES, 2, flops per input synchroniser (>=2)
SETTLE_CYC, 4, clk cycles um_ena stays low after any address change or enable request (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ctrl_sel_rst_n  input  1  raw pad, async; low clears address
ctrl_sel_inc  input  1  raw pad, async; each rising edge increments address
ctrl_ena  input  1  raw pad, async; high requests selected design enabled
sel  output  SEL_W  current design-select address
um_ena  output  1  enable to selected user module (spine ena bit)
busy  output  1  high while in SETTLE
sel_chg  output  1  one-cycle pulse on the cycle sel changes

Behaviour:
- Reset (rst_n low, async): sel=0, um_ena=0, busy=0, sel_chg=0, FSM=OFF, settle counter=0.
- Reset values of the synchroniser chains:
  - ctrl_sel_inc chain and its edge-detect history reset to 1, so a pin already high at reset release is not an edge.
  - ctrl_ena chain resets to 0.
  - ctrl_sel_rst_n chain resets to 0, so the address stays cleared until the synchronised pin reads high.
- Synchronised value (x_s) is valid SYNC_STAGES clk edges after the pin is first sampled.
- inc_edge = inc_s & ~inc_d; this is a one-cycle strobe.
- Address update, registered on the edge after the synchronised event:
  - sel_rst_s==0: sel<=0. sel_chg=1 only if sel was nonzero. inc_edge is ignored (clear wins).
  - else if inc_edge: sel <= (sel==MAX_SEL) ? 0 : sel+1, and sel_chg=1.
  - else: hold.
- Latency, pad edge to sel update: SYNC_STAGES+1 clk edges (3 with defaults).
- FSM states OFF, SETTLE, ON. ena_ok = ena_s & sel_rst_s.
  - OFF: um_ena=0. If ena_ok, go to SETTLE and load cnt=SETTLE_CYC-1.
  - SETTLE: busy=1, um_ena=0.
    - ~ena_ok: go to OFF.
    - sel_chg event this cycle: reload cnt=SETTLE_CYC-1 and stay.
    - cnt==0: go to ON.
    - otherwise cnt-=1.
  - ON: um_ena=1.
    - ~ena_ok: go to OFF. um_ena drops on the same edge.
    - sel_chg event: go to SETTLE with reload. um_ena drops on the same edge the new sel appears, so um_ena is never high with a stale sel.
- Enable latency: pad ena rise to um_ena rise = SYNC_STAGES+1+SETTLE_CYC edges (7 default).
- Simultaneous ena fall and inc_edge: address still increments, FSM goes to OFF.
- um_ena and busy are registered outputs (FSM-decoded flops). No combinational path from pads to outputs.
- rst_n asserted mid-SETTLE or mid-ON: outputs return to reset values immediately (async).

Decomposition:
- Package tt_ctrl_pkg holds:
  - FSM state enum (OFF=0, SETTLE=1, ON=2, 2-bit).
  - Default SEL_W constant.
  - Spine select-field width/offset constants shared with the controller and mux.
- Sub-module tt_sync_edge:
  - Parameterised SYNC_STAGES and reset value RST_VAL.
  - Outputs the synchronised level and a rising-edge strobe.
  - Instantiated three times.

Test Plan:
- Reset release with ctrl_sel_inc pin held high, sel_rst_n=1 -> no inc_edge; sel stays 0, sel_chg never pulses.
- sel_rst_n=1, ena=0, five clean inc pulses (each 4 clk high / 4 low) -> sel=5. Each update lands 3 edges after its pin rise, with one sel_chg pulse per step.
- Preload sel=1023 via 1023 pulses, then one more pulse -> sel wraps to 0 with one sel_chg pulse; with MAX_SEL=5, the sixth pulse wraps sel 5->0.
- sel=3, raise ena at cycle 0 -> busy=1 from edge 3 to 6, um_ena=1 from edge 7. Drop ena -> um_ena=0 exactly 3 edges after the pin fall.
- In ON with sel=3, one inc pulse -> um_ena falls on the same edge sel becomes 4, busy=1 for 4 cycles, um_ena returns. A second inc mid-SETTLE restarts the 4-cycle count.
- In ON, pull sel_rst_n low -> sel=0 and FSM=OFF on edge 3. Assert rst_n low mid-SETTLE -> all outputs 0 asynchronously, before the next clk edge.
